div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter N, default 32: operand/result width in bits.
REQ-002 Parameter A, default $clog2(N): register-address width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; accepted only when busy=0.
REQ-006 op  input  2  operation: DIV=00, DIVU=01, REM=10, REMU=11.
REQ-007 a  input  N  dividend (rd1 from register file).
REQ-008 b  input  N  divisor (rd2 from register file).
REQ-009 rd_addr  input  A  destination register index.
REQ-010 busy  output  1  high from accept edge until done cycle, inclusive.
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 result  output  N  quotient or remainder per op.
REQ-013 wb_we  output  1  register-file write enable (drives we3).
REQ-014 wb_addr  output  A  register-file write index (drives addr3); result drives wd3.

Function
REQ-015 FSM states IDLE, RUN, DONE; IDLE->RUN on accepted start; RUN->DONE after N iterations; DONE->IDLE after one cycle.
REQ-016 On accept, capture op, rd_addr, |a|, |b| (signed ops) or a, b raw (unsigned ops), and result signs; iteration counter loads N.
REQ-017 RUN performs one restoring shift-subtract step per cycle, producing one quotient bit MSB-first; counter decrements, N steps exactly.
REQ-018 Sign fix: signed quotient negated when sign(a)!=sign(b); signed remainder takes sign of a.
REQ-019 Normal latency: done high exactly N+1 cycles after the accept cycle (33 for N=32).
REQ-020 Divide by zero: skip RUN, enter DONE next cycle; quotient all ones, remainder = a (both signed and unsigned).
REQ-021 Signed overflow (a=most-negative, b=-1, op DIV/REM): skip RUN, enter DONE next cycle; quotient = a, remainder = 0.
REQ-022 start while busy=1 ignored; no capture, no effect on in-flight operation.
REQ-023 start in DONE cycle ignored; earliest new accept is the cycle after done.
REQ-024 wb_we = done AND (captured rd_addr != 0); done pulses regardless.
REQ-025 wb_addr = captured rd_addr; result registered, held stable from done until next accepted start.
REQ-026 Inputs a, b, op, rd_addr sampled only on the accept edge; later changes have no effect.

Reset
REQ-027 rst asserted: state=IDLE immediately; busy=0, done=0, wb_we=0, result=0, wb_addr=0, counter=0.
REQ-028 rst mid-operation aborts it; no done, no wb_we pulse for the aborted operation.
REQ-029 First accept possible on the first rising edge after rst deasserts.

Structure
REQ-030 Shared package riscv_pkg holds div_op_e enum (DIV/DIVU/REM/REMU encodings) and N default constant.
REQ-031 FSM state enum local to div_unit.
REQ-032 Single module; no sub-module; iteration step is inline combinational logic.

Verification
REQ-033 DIVU a=100 b=7 -> done at cycle 33 after accept, result=14, wb_we=1 with wb_addr=rd_addr.
REQ-034 DIV a=-7 b=2 -> result=-3; REM a=-7 b=2 -> result=-1; REMU a=0xFFFFFFF9 b=2 -> result=1.
REQ-035 DIVU a=5 b=0 -> done 1 cycle after accept, result=0xFFFFFFFF; REM a=5 b=0 -> result=5.
REQ-036 DIV a=0x80000000 b=0xFFFFFFFF -> done 1 cycle after accept, result=0x80000000; REM same -> 0.
REQ-037 start pulsed at cycle 10 during RUN with different operands -> original result unchanged, done at cycle 33 only; rd_addr=0 -> done=1, wb_we=0.
REQ-038 rst asserted at cycle 15 of RUN -> busy=0 immediately, no done/wb_we; fresh DIVU 9/3 afterward -> result=3 after 33 cycles.

Source files
------------

// File: rtl/riscv_pkg.sv
// Definitions shared by the integer core: divider opcodes and default datapath width.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

endpackage

// File: rtl/div_unit_if.sv
// Request/writeback bundle between the issue stage and the divider.
interface div_unit_if
    import riscv_pkg::*;
#(
    parameter int N = XLEN,
    parameter int A = $clog2(N)
);
    logic           start;
    div_op_e        op;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [A-1:0]   rd_addr;
    logic           busy;
    logic           done;
    logic [N-1:0]   result;
    logic           wb_we;
    logic [A-1:0]   wb_addr;

    modport master (
        output start, op, a, b, rd_addr,
        input  busy, done, result, wb_we, wb_addr
    );

    modport slave (
        input  start, op, a, b, rd_addr,
        output busy, done, result, wb_we, wb_addr
    );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider: one quotient bit per cycle, with shortcut paths for
// divide-by-zero and signed overflow, writing its result back to the register file.
module div_unit
    import riscv_pkg::*;
#(
    parameter int N = XLEN,
    parameter int A = $clog2(N)
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);

    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    rem_q, rem_d;
    logic [N-1:0]    quo_q, quo_d;
    logic [N-1:0]    dvs_q, dvs_d;
    logic            is_rem_q, is_rem_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic [A-1:0]    addr_q, addr_d;
    logic [N-1:0]    result_q, result_d;
    logic            done_q, done_d;
    logic            wb_we_q, wb_we_d;

    logic            accept_s;
    logic            is_signed_s;
    logic            is_rem_s;
    logic            a_neg_s;
    logic            b_neg_s;
    logic [N-1:0]    a_mag_s;
    logic [N-1:0]    b_mag_s;
    logic            div0_s;
    logic            ovf_s;
    logic [N-1:0]    special_res_s;
    logic [N:0]      shift_s;
    logic [N:0]      diff_s;
    logic            take_s;
    logic [N-1:0]    step_rem_s;
    logic [N-1:0]    step_quo_s;
    logic [N-1:0]    q_fix_s;
    logic [N-1:0]    r_fix_s;
    logic [N-1:0]    final_res_s;

    // Operand decode at the accept edge: magnitudes, signs and shortcut cases.
    always_comb begin
        accept_s    = bus.start && (state_q == S_IDLE);
        is_signed_s = (bus.op == OP_DIV) || (bus.op == OP_REM);
        is_rem_s    = (bus.op == OP_REM) || (bus.op == OP_REMU);
        a_neg_s     = is_signed_s && bus.a[N-1];
        b_neg_s     = is_signed_s && bus.b[N-1];
        a_mag_s     = a_neg_s ? (~bus.a + {{(N-1){1'b0}}, 1'b1}) : bus.a;
        b_mag_s     = b_neg_s ? (~bus.b + {{(N-1){1'b0}}, 1'b1}) : bus.b;
        div0_s      = (bus.b == {N{1'b0}});
        ovf_s       = is_signed_s && (bus.a == MOST_NEG) && (bus.b == {N{1'b1}});
        if (div0_s) begin
            special_res_s = is_rem_s ? bus.a : {N{1'b1}};
        end else begin
            special_res_s = is_rem_s ? {N{1'b0}} : bus.a;
        end
    end

    // One restoring shift-subtract step plus sign correction of its outcome.
    always_comb begin
        shift_s     = {rem_q, quo_q[N-1]};
        diff_s      = shift_s - {1'b0, dvs_q};
        take_s      = ~diff_s[N];
        step_rem_s  = take_s ? diff_s[N-1:0] : shift_s[N-1:0];
        step_quo_s  = {quo_q[N-2:0], take_s};
        q_fix_s     = q_neg_q ? (~step_quo_s + {{(N-1){1'b0}}, 1'b1}) : step_quo_s;
        r_fix_s     = r_neg_q ? (~step_rem_s + {{(N-1){1'b0}}, 1'b1}) : step_rem_s;
        final_res_s = is_rem_q ? r_fix_s : q_fix_s;
    end

    // Next-state and output logic of the control FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        is_rem_d = is_rem_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        addr_d   = addr_q;
        result_d = result_q;
        done_d   = 1'b0;
        wb_we_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    addr_d   = bus.rd_addr;
                    is_rem_d = is_rem_s;
                    q_neg_d  = a_neg_s ^ b_neg_s;
                    r_neg_d  = a_neg_s;
                    if (div0_s || ovf_s) begin
                        state_d  = S_DONE;
                        cnt_d    = {CW{1'b0}};
                        result_d = special_res_s;
                        done_d   = 1'b1;
                        wb_we_d  = (bus.rd_addr != {A{1'b0}});
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = CW'(N);
                        rem_d   = {N{1'b0}};
                        quo_d   = a_mag_s;
                        dvs_d   = b_mag_s;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                rem_d = step_rem_s;
                quo_d = step_quo_s;
                cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                // The last step's outcome goes straight to the result register.
                if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
                    state_d  = S_DONE;
                    result_d = final_res_s;
                    done_d   = 1'b1;
                    wb_we_d  = (addr_q != {A{1'b0}});
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            rem_q    <= {N{1'b0}};
            quo_q    <= {N{1'b0}};
            dvs_q    <= {N{1'b0}};
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            addr_q   <= {A{1'b0}};
            result_q <= {N{1'b0}};
            done_q   <= 1'b0;
            wb_we_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            is_rem_q <= is_rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            addr_q   <= addr_d;
            result_q <= result_d;
            done_q   <= done_d;
            wb_we_q  <= wb_we_d;
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.wb_we   = wb_we_q;
    assign bus.wb_addr = addr_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a vector table for the arithmetic, plus hand-written
// sequences for start-while-busy, start-in-done and reset-mid-operation.
module tb_div_unit;
    import riscv_pkg::*;

    localparam int N = 32;
    localparam int A = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    div_unit_if #(.N(N), .A(A)) bus ();

    div_unit #(.N(N), .A(A)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        div_op_e      op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [A-1:0] rd;
        logic [N-1:0] exp_res;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    function automatic void add(input div_op_e op, input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic [A-1:0] rd, input logic [N-1:0] r, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.rd = rd; v.exp_res = r; v.lat = lat;
        vecs.push_back(v);
    endfunction

    // Presents a request for one cycle; leaves time at accept edge + 1 with operands scrambled.
    task automatic issue(input div_op_e op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [A-1:0] rd);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.a       = a;
        bus.b       = b;
        bus.rd_addr = rd;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.op      = OP_REMU;
        bus.a       = $urandom;
        bus.b       = $urandom;
        bus.rd_addr = 5'd31;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    int lat;

    initial begin
        bus.start   = 1'b0;
        bus.op      = OP_DIV;
        bus.a       = 32'd0;
        bus.b       = 32'd0;
        bus.rd_addr = 5'd0;

        add(OP_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         33);
        add(OP_DIV,  32'hFFFFFFF9,   32'd2,          5'd6,  32'hFFFFFFFD,   33);
        add(OP_REM,  32'hFFFFFFF9,   32'd2,          5'd7,  32'hFFFFFFFF,   33);
        add(OP_REMU, 32'hFFFFFFF9,   32'd2,          5'd8,  32'd1,          33);
        add(OP_DIVU, 32'd5,          32'd0,          5'd9,  32'hFFFFFFFF,   1);
        add(OP_REM,  32'd5,          32'd0,          5'd10, 32'd5,          1);
        add(OP_DIV,  32'h80000000,   32'hFFFFFFFF,   5'd11, 32'h80000000,   1);
        add(OP_REM,  32'h80000000,   32'hFFFFFFFF,   5'd12, 32'd0,          1);
        add(OP_DIV,  32'd7,          32'hFFFFFFFE,   5'd13, 32'hFFFFFFFD,   33);
        add(OP_REM,  32'd7,          32'hFFFFFFFE,   5'd14, 32'd1,          33);
        add(OP_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   5'd15, 32'd14,         33);
        add(OP_REM,  32'hFFFFFF9C,   32'hFFFFFFF9,   5'd16, 32'hFFFFFFFE,   33);
        add(OP_DIVU, 32'hFFFFFFFF,   32'd1,          5'd0,  32'hFFFFFFFF,   33);
        add(OP_DIV,  32'h80000000,   32'd2,          5'd17, 32'hC0000000,   33);
        add(OP_DIV,  32'hFFFFFFFB,   32'd0,          5'd18, 32'hFFFFFFFF,   1);
        add(OP_REMU, 32'h80000000,   32'd0,          5'd19, 32'h80000000,   1);
        add(OP_DIVU, 32'd3,          32'd10,         5'd20, 32'd0,          33);
        add(OP_REMU, 32'd3,          32'd10,         5'd21, 32'd3,          33);
        add(OP_REM,  32'h80000000,   32'd3,          5'd22, 32'hFFFFFFFE,   33);

        // Reset state.
        @(negedge clk);
        chk("rst_busy",    bus.busy,    1'b0);
        chk("rst_done",    bus.done,    1'b0);
        chk("rst_wb_we",   bus.wb_we,   1'b0);
        chk("rst_result",  bus.result,  32'd0);
        chk("rst_wb_addr", bus.wb_addr, 5'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
            chk($sformatf("v%0d_busy", i), bus.busy, 1'b1);
            wait_done(lat);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_result", i), bus.result, vecs[i].exp_res);
            chk($sformatf("v%0d_wb_we", i), bus.wb_we, (vecs[i].rd != 5'd0));
            chk($sformatf("v%0d_wb_addr", i), bus.wb_addr, vecs[i].rd);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), bus.done, 1'b0);
            chk($sformatf("v%0d_idle", i), bus.busy, 1'b0);
            chk($sformatf("v%0d_hold", i), bus.result, vecs[i].exp_res);
        end

        // Start pulsed mid-run with other operands must be ignored.
        issue(OP_DIVU, 32'd100, 32'd7, 5'd9);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (lat == 9) begin
                bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd1000; bus.b = 32'd3; bus.rd_addr = 5'd4;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        chk("busy_ign_lat",     lat,         33);
        chk("busy_ign_result",  bus.result,  32'd14);
        chk("busy_ign_wb_addr", bus.wb_addr, 5'd9);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("busy_ign_quiet%0d", k), {bus.busy, bus.done}, 2'b00);
        end

        // Start held through the done cycle: ignored there, accepted one cycle later.
        issue(OP_DIVU, 32'd5, 32'd0, 5'd2);
        chk("done_ign_first", bus.done, 1'b1);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd8; bus.b = 32'd0; bus.rd_addr = 5'd6;
        @(posedge clk);
        #1;
        chk("done_ign_busy", bus.busy, 1'b0);
        chk("done_ign_done", bus.done, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("next_acc_done",    bus.done,    1'b1);
        chk("next_acc_result",  bus.result,  32'hFFFFFFFF);
        chk("next_acc_wb_addr", bus.wb_addr, 5'd6);

        // Reset in the middle of a run aborts it without any writeback.
        issue(OP_DIVU, 32'h0000FFFF, 32'd3, 5'd7);
        lat = 1;
        while (lat < 15) begin
            @(posedge clk);
            #1;
            lat++;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy",    bus.busy,    1'b0);
        chk("abort_done",    bus.done,    1'b0);
        chk("abort_wb_we",   bus.wb_we,   1'b0);
        chk("abort_result",  bus.result,  32'd0);
        chk("abort_wb_addr", bus.wb_addr, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_held_done", bus.done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        issue(OP_DIVU, 32'd9, 32'd3, 5'd1);
        wait_done(lat);
        chk("post_rst_lat",    lat,        33);
        chk("post_rst_result", bus.result, 32'd3);
        chk("post_rst_wb_we",  bus.wb_we,  1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
